frame_reader: RTL and testbench

Raster-order pixel source for the Sobel pipeline. On a start pulse it walks a stored frame in a synchronous-read frame memory, address 0 to IMG_WIDTH*IMG_HEIGHT-1, and emits the pixels as a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers. It is the read side of the frame memory and sits upstream of the line buffer and window logic. It absorbs downstream backpressure without losing or duplicating pixels.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/frame_reader_if.sv | 33 +++
 rtl/stream_fifo2.sv | 46 ++++
 rtl/frame_reader.sv | 126 ++++++++++++
 tb/tb_frame_reader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: default frame geometry,
// reader state encoding and the width of the sof/eol/eof marker bundle.
package sobel_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_IMG_WIDTH  = 128;
   localparam int DEF_IMG_HEIGHT = 128;
   localparam int MARK_W         = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Counter width that never collapses to zero bits for degenerate sizes.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_reader_if.sv
// Control, frame-memory read port and pixel stream of the frame reader.
interface frame_reader_if
   import sobel_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = 14
);
   logic                  start_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  mem_rd_en_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_data_i;
   logic [DATA_WIDTH-1:0] pixel_o;
   logic                  valid_o;
   logic                  ready_i;
   logic                  sof_o;
   logic                  eol_o;
   logic                  eof_o;

   modport master (
      input  start_i, mem_data_i, ready_i,
      output busy_o, done_o, mem_rd_en_o, mem_addr_o,
             pixel_o, valid_o, sof_o, eol_o, eof_o
   );

   modport slave (
      output start_i, mem_data_i, ready_i,
      input  busy_o, done_o, mem_rd_en_o, mem_addr_o,
             pixel_o, valid_o, sof_o, eol_o, eof_o
   );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO for returned pixels plus markers; head is
// presented combinationally from storage, so it holds while not popped.
module stream_fifo2 #(
   parameter int W = 11
) (
   input  logic         i_clk,
   input  logic         i_flush_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic [1:0]   o_fill
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_fill;
   logic         w_pop;

   assign w_pop   = i_pop & o_valid;
   assign o_valid = (r_fill != 2'd0);
   assign o_data  = r_mem[r_rptr];
   assign o_fill  = r_fill;

   always_ff @(posedge i_clk) begin
      if (!i_flush_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_fill   <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_fill <= r_fill + {1'b0, i_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/frame_reader.sv
// Raster-order frame reader: walks the frame memory and emits a valid/ready
// pixel stream with sof/eol/eof, never holding more than two pixels in flight.
module frame_reader
   import sobel_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input logic            clk_i,
   input logic            rst_n_i,
   frame_reader_if.master bus
);

   localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;
   localparam int ADDR_WIDTH = clog2_min1(NPIX);
   localparam int COL_W      = clog2_min1(IMG_WIDTH);
   localparam int ROW_W      = clog2_min1(IMG_HEIGHT);
   localparam int FW         = DATA_WIDTH + MARK_W;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic                  r_inflight;
   logic [MARK_W-1:0]     r_mk;
   logic                  r_done;

   logic                  w_rd_en;
   logic                  w_pop;
   logic                  w_sof;
   logic                  w_eol;
   logic                  w_last;
   logic                  w_head_valid;
   logic [1:0]            w_fill;
   logic [FW-1:0]         w_head;

   assign w_sof  = (r_addr == '0);
   assign w_eol  = (r_col == COL_LAST);
   assign w_last = (r_row == ROW_LAST) && w_eol;
   assign w_pop  = w_head_valid & bus.ready_i;

   // Issue only while the FIFO can still absorb every read already in flight;
   // counting this cycle's pop keeps full throughput when ready is high.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start_i) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (({1'b0, w_fill} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop})) begin
               w_rd_en = 1'b1;
               if (w_last) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_pop && w_head[FW-1]) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_addr     <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         r_done     <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
         if (r_state == ST_IDLE && bus.start_i) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
         end else if (w_rd_en) begin
            r_addr <= r_addr + 1'b1;
            if (w_eol) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   // Markers ride one cycle behind the read, aligned with mem_data_i.
   always_ff @(posedge clk_i) begin
      if (w_rd_en) r_mk <= {w_last, w_eol, w_sof};
   end

   stream_fifo2 #(.W(FW)) u_fifo (
      .i_clk     (clk_i),
      .i_flush_n (rst_n_i),
      .i_push    (r_inflight),
      .i_data    ({r_mk, bus.mem_data_i}),
      .i_pop     (bus.ready_i),
      .o_data    (w_head),
      .o_valid   (w_head_valid),
      .o_fill    (w_fill)
   );

   assign bus.mem_rd_en_o = w_rd_en;
   assign bus.mem_addr_o  = r_addr;
   assign bus.busy_o      = (r_state != ST_IDLE);
   assign bus.done_o      = r_done;
   assign bus.valid_o     = w_head_valid;
   assign bus.pixel_o     = w_head_valid ? w_head[DATA_WIDTH-1:0] : '0;
   assign bus.sof_o       = w_head_valid & w_head[DATA_WIDTH];
   assign bus.eol_o       = w_head_valid & w_head[DATA_WIDTH+1];
   assign bus.eof_o       = w_head_valid & w_head[DATA_WIDTH+2];

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a 4x3 instance driven with directed and random
// ready patterns, plus a 1x1 instance, checked against a raster-order model.
module tb_frame_reader;
   import sobel_pkg::*;

   localparam int WA = 4;
   localparam int HA = 3;
   localparam int NA = WA * HA;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   logic [7:0] base_a;
   logic [7:0] base_b;

   frame_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifa ();
   frame_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) ifb ();

   frame_reader #(.DATA_WIDTH(8), .IMG_WIDTH(WA), .IMG_HEIGHT(HA)) dut_a (
      .clk_i   (clk),
      .rst_n_i (rst_a),
      .bus     (ifa)
   );

   frame_reader #(.DATA_WIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_b (
      .clk_i   (clk),
      .rst_n_i (rst_b),
      .bus     (ifb)
   );

   // Synchronous-read frame memories: contents are address plus a per-frame base.
   always @(posedge clk) begin
      if (ifa.mem_rd_en_o) ifa.mem_data_i <= 8'(ifa.mem_addr_o) + base_a;
      if (ifb.mem_rd_en_o) ifb.mem_data_i <= base_b ^ {7'd0, ifb.mem_addr_o};
   end

   int n_checks = 0;
   int n_errors = 0;
   int exp_idx, reads, cyc, start_cyc, first_cyc, done_cyc;
   bit prev_stall, saw_done, auto_restart;
   logic [10:0] prev_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {eof, eol, sof, pixel} of raster position i in the 4x3 frame.
   function automatic logic [10:0] ref_pix(input int i, input logic [7:0] base);
      logic [7:0] p;
      p = 8'(i) + base;
      return {(i == NA - 1), ((i % WA) == WA - 1), (i == 0), p};
   endfunction

   task automatic sb_clear();
      exp_idx    = 0;
      reads      = 0;
      prev_stall = 1'b0;
      saw_done   = 1'b0;
      first_cyc  = -1;
      done_cyc   = -1;
   endtask

   task automatic step(input bit rdy, input bit st, input bit rlo);
      logic [10:0] obs;
      @(negedge clk);
      ifa.ready_i = rdy;
      ifa.start_i = st | (auto_restart & ifa.done_o);
      rst_a       = !rlo;
      #1;
      cyc++;
      obs = {ifa.eof_o, ifa.eol_o, ifa.sof_o, ifa.pixel_o};
      if (prev_stall) begin
         chk("hold_valid", ifa.valid_o, 1);
         chk("hold_data", obs, prev_out);
      end
      if (ifa.valid_o && rdy) begin
         chk("pix_in_range", exp_idx < NA, 1);
         chk($sformatf("pix%0d", exp_idx), obs, ref_pix(exp_idx, base_a));
         if (exp_idx == 0) first_cyc = cyc;
         exp_idx++;
      end
      if (ifa.mem_rd_en_o) begin
         chk("rd_addr", ifa.mem_addr_o, reads);
         reads++;
      end
      chk("outstanding", (reads - exp_idx) <= 2, 1);
      prev_stall = ifa.valid_o && !rdy;
      prev_out   = obs;
      if (ifa.done_o) begin
         chk("done_after_eof", exp_idx, NA);
         chk("done_busy", ifa.busy_o, 0);
         done_cyc = cyc;
         saw_done = 1'b1;
      end
   endtask

   task automatic start_frame(input bit new_base);
      sb_clear();
      if (new_base) base_a = 8'($urandom);
      step(1'b1, 1'b1, 1'b0);
      start_cyc = cyc;
   endtask

   task automatic run_frame(input bit rnd, input int mid_start_at, input int budget);
      bit r;
      for (int i = 0; i < budget && !saw_done; i++) begin
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step(r, (i == mid_start_at), 1'b0);
      end
      chk("frame_done_seen", saw_done, 1);
   endtask

   initial begin
      rst_a        = 1'b0;
      rst_b        = 1'b0;
      auto_restart = 1'b0;
      base_a       = 8'h00;
      base_b       = 8'($urandom);
      cyc          = 0;
      ifa.start_i  = 1'b0;
      ifa.ready_i  = 1'b0;
      ifb.start_i  = 1'b0;
      ifb.ready_i  = 1'b0;
      sb_clear();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", ifa.busy_o, 0);
      chk("rst_done", ifa.done_o, 0);
      chk("rst_rden", ifa.mem_rd_en_o, 0);
      chk("rst_valid", ifa.valid_o, 0);
      chk("rst_marks", {ifa.sof_o, ifa.eol_o, ifa.eof_o}, 0);
      chk("rst_addr", ifa.mem_addr_o, 0);
      chk("rst_pixel", ifa.pixel_o, 0);
      chk("rst_b_valid", ifb.valid_o, 0);
      rst_b = 1'b1;
      step(1'b1, 1'b0, 1'b0);

      // Full-rate frame with latency checks.
      start_frame(1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("k_rden", ifa.mem_rd_en_o, 1);
      chk("k_busy", ifa.busy_o, 1);
      chk("k_valid", ifa.valid_o, 0);
      run_frame(1'b0, -1, 40);
      chk("first_latency", first_cyc - start_cyc, 3);
      chk("done_latency", done_cyc - start_cyc, 3 + NA);
      chk("count_full", exp_idx, NA);

      // Random backpressure, with a start pulse mid-frame that must be ignored.
      for (int f = 0; f < 3; f++) begin
         start_frame(1'b1);
         run_frame(1'b1, 4, 300);
         chk("count_rand", exp_idx, NA);
      end

      // Long stall right after start.
      start_frame(1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
      chk("stall_reads", reads, 2);
      chk("stall_valid", ifa.valid_o, 1);
      run_frame(1'b0, -1, 40);
      chk("count_stall", exp_idx, NA);

      // Back-to-back: start in the done cycle, second frame begins at address 0.
      start_frame(1'b1);
      auto_restart = 1'b1;
      run_frame(1'b0, -1, 40);
      auto_restart = 1'b0;
      sb_clear();
      step(1'b1, 1'b0, 1'b0);
      chk("b2b_rden", ifa.mem_rd_en_o, 1);
      chk("b2b_busy", ifa.busy_o, 1);
      run_frame(1'b0, -1, 40);
      chk("count_b2b", exp_idx, NA);

      // Reset mid-frame at pixel 5, then replay.
      start_frame(1'b1);
      for (int i = 0; i < 50 && exp_idx < 5; i++) step(1'b1, 1'b0, 1'b0);
      chk("reached_pix5", exp_idx, 5);
      step(1'b1, 1'b0, 1'b1);
      sb_clear();
      step(1'b1, 1'b0, 1'b0);
      chk("mrst_busy", ifa.busy_o, 0);
      chk("mrst_done", ifa.done_o, 0);
      chk("mrst_valid", ifa.valid_o, 0);
      chk("mrst_marks", {ifa.sof_o, ifa.eol_o, ifa.eof_o}, 0);
      chk("mrst_addr", ifa.mem_addr_o, 0);
      chk("mrst_pixel", ifa.pixel_o, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0);
         chk("no_stale_valid", ifa.valid_o, 0);
         chk("no_stale_rden", ifa.mem_rd_en_o, 0);
      end
      start_frame(1'b1);
      run_frame(1'b0, -1, 40);
      chk("count_replay", exp_idx, NA);

      // 1x1 frame.
      @(negedge clk);
      ifb.ready_i = 1'b1;
      ifb.start_i = 1'b1;
      @(negedge clk);
      ifb.start_i = 1'b0;
      #1;
      chk("b_rden", ifb.mem_rd_en_o, 1);
      chk("b_addr", ifb.mem_addr_o, 0);
      chk("b_busy", ifb.busy_o, 1);
      @(negedge clk);
      #1;
      chk("b_valid_early", ifb.valid_o, 0);
      chk("b_rden_once", ifb.mem_rd_en_o, 0);
      @(negedge clk);
      #1;
      chk("b_valid", ifb.valid_o, 1);
      chk("b_pix", {ifb.eof_o, ifb.eol_o, ifb.sof_o, ifb.pixel_o}, {3'b111, base_b});
      chk("b_done_early", ifb.done_o, 0);
      @(negedge clk);
      #1;
      chk("b_done", ifb.done_o, 1);
      chk("b_busy_end", ifb.busy_o, 0);
      chk("b_valid_end", ifb.valid_o, 0);
      @(negedge clk);
      #1;
      chk("b_done_pulse", ifb.done_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
